// File: rtl/pipeline_hazard_sb_if.sv
// Hazard-unit bus: D/E/W stage status in from the pipeline, latch enables,
// flushes and counters out to the pipeline.
interface pipeline_hazard_sb_if #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LAT_W   = 4,
    parameter int CNT_W      = 16
);
    logic                  valid_D;
    logic                  reg_flag_D;
    logic                  use_rs1_D;
    logic                  use_rs2_D;
    logic [REG_ADDR_W-1:0] rs1_D;
    logic [REG_ADDR_W-1:0] rs2_D;
    logic [REG_ADDR_W-1:0] rd_D;
    logic [REG_ADDR_W-1:0] rd_W;
    logic                  reg_flag_W;
    logic                  branch_E;
    logic                  mc_start_E;
    logic [MC_LAT_W-1:0]   mc_lat_E;

    logic enable_IFU, enable_F_D, enable_D_R, enable_R_E, enable_E_W;
    logic flush_IFU, flush_F_D, flush_D_R, flush_R_E, flush_E_W;
    logic                  mc_busy;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;
    // Multi-cycle FSM state for observation (0 idle, 1 busy, 2 release).
    logic [1:0]            mc_state;

    // Handshake: there is no valid/ready pair here; every signal is a
    // per-cycle level. The pipeline presents stage status each cycle and the
    // hazard unit answers combinationally in the same cycle.
    modport master (
        output valid_D, reg_flag_D, use_rs1_D, use_rs2_D, rs1_D, rs2_D, rd_D,
               rd_W, reg_flag_W, branch_E, mc_start_E, mc_lat_E,
        input  enable_IFU, enable_F_D, enable_D_R, enable_R_E, enable_E_W,
               flush_IFU, flush_F_D, flush_D_R, flush_R_E, flush_E_W,
               mc_busy, stall_cycles, flush_events, mc_state
    );

    modport slave (
        input  valid_D, reg_flag_D, use_rs1_D, use_rs2_D, rs1_D, rs2_D, rd_D,
               rd_W, reg_flag_W, branch_E, mc_start_E, mc_lat_E,
        output enable_IFU, enable_F_D, enable_D_R, enable_R_E, enable_E_W,
               flush_IFU, flush_F_D, flush_D_R, flush_R_E, flush_E_W,
               mc_busy, stall_cycles, flush_events, mc_state
    );
endinterface

// File: rtl/pipeline_hazard_sb.sv
// Scoreboard hazard unit for the F/D/R/E/W pipeline: per-register pending
// bits, branch rollback of the op in R, multi-cycle execute freeze and
// saturating stall/flush counters.
module pipeline_hazard_sb #(
    parameter int REG_ADDR_W = 5,
    parameter int NREGS      = 2**REG_ADDR_W,
    parameter int MC_LAT_W   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    pipeline_hazard_sb_if.slave bus
);
    typedef enum logic [1:0] {
        MC_IDLE    = 2'd0,
        MC_BUSY    = 2'd1,
        MC_RELEASE = 2'd2
    } mc_state_t;

    localparam logic [MC_LAT_W-1:0] LAT_ONE = 1;

    mc_state_t             state, state_n;
    logic [MC_LAT_W-1:0]   cnt, cnt_n;
    logic [NREGS-1:0]      pend, pend_n;
    logic                  tag_v, tag_v_n;
    logic [REG_ADDR_W-1:0] tag_rd, tag_rd_n;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;

    logic fsm_freeze, freeze, branch_act, data_stall, stall_act, issue;
    logic [4:0] en, fl;

    // Multi-cycle FSM: next state, countdown and raw freeze request.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        fsm_freeze = 1'b0;
        case (state)
            MC_IDLE: begin
                if (bus.mc_start_E && bus.mc_lat_E != '0 && !bus.branch_E) begin
                    fsm_freeze = 1'b1;
                    cnt_n      = bus.mc_lat_E - LAT_ONE;
                    state_n    = (bus.mc_lat_E == LAT_ONE) ? MC_RELEASE : MC_BUSY;
                end
            end
            MC_BUSY: begin
                fsm_freeze = 1'b1;
                cnt_n      = cnt - LAT_ONE;
                if (cnt == LAT_ONE) state_n = MC_RELEASE;
            end
            MC_RELEASE: state_n = MC_IDLE;
            default:    state_n = MC_IDLE;
        endcase
    end

    // Mode decode (freeze > branch > data stall); reset forces default mode.
    always_comb begin
        data_stall = bus.valid_D &&
                     ((bus.use_rs1_D && bus.rs1_D != '0 && pend[bus.rs1_D]) ||
                      (bus.use_rs2_D && bus.rs2_D != '0 && pend[bus.rs2_D]) ||
                      (bus.reg_flag_D && bus.rd_D != '0 && pend[bus.rd_D]));
        freeze     = !reset && fsm_freeze;
        branch_act = !reset && !fsm_freeze && bus.branch_E;
        stall_act  = !reset && !fsm_freeze && !bus.branch_E && data_stall;
        issue      = !reset && !fsm_freeze && !bus.branch_E && !data_stall &&
                     bus.valid_D && bus.reg_flag_D && bus.rd_D != '0;
        // en/fl order: IFU, F_D, D_R, R_E, E_W
        en = 5'b11111;
        fl = 5'b00000;
        if (freeze) begin
            en = 5'b00001;
            fl = 5'b00001;
        end else if (branch_act) begin
            fl = 5'b11110;
        end else if (stall_act) begin
            en = 5'b00111;
            fl = 5'b00100;
        end
    end

    // Scoreboard and R-stage tag next values: retire, rollback, issue.
    always_comb begin
        pend_n   = pend;
        tag_v_n  = tag_v;
        tag_rd_n = tag_rd;
        if (bus.reg_flag_W && bus.rd_W != '0) pend_n[bus.rd_W] = 1'b0;
        if (fl[1] && tag_v) pend_n[tag_rd] = 1'b0;
        if (issue) pend_n[bus.rd_D] = 1'b1;
        // D_R loading or flushing always replaces whatever R held.
        if (en[2] || fl[2]) begin
            tag_v_n  = issue;
            tag_rd_n = issue ? bus.rd_D : '0;
        end
    end

    // State registers and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MC_IDLE;
            cnt       <= '0;
            pend      <= '0;
            tag_v     <= 1'b0;
            tag_rd    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pend   <= pend_n;
            tag_v  <= tag_v_n;
            tag_rd <= tag_rd_n;
            if ((freeze || stall_act) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (branch_act && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign {bus.enable_IFU, bus.enable_F_D, bus.enable_D_R, bus.enable_R_E, bus.enable_E_W} = en;
    assign {bus.flush_IFU, bus.flush_F_D, bus.flush_D_R, bus.flush_R_E, bus.flush_E_W} = fl;
    assign bus.mc_busy      = freeze;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;
    assign bus.mc_state     = state;
endmodule

// File: tb/tb_pipeline_hazard_sb.sv
// Self-checking bench for pipeline_hazard_sb: directed hazard scenarios with
// an expected-output queue and a counter model driven by expected modes.
module tb_pipeline_hazard_sb;
  localparam logic [10:0] V_DEF   = 11'b11111_00000_0;
  localparam logic [10:0] V_STALL = 11'b00111_00100_0;
  localparam logic [10:0] V_BR    = 11'b11111_11110_0;
  localparam logic [10:0] V_FRZ   = 11'b00001_00001_1;

  logic clk;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [10:0] exp_q[$];

  pipeline_hazard_sb_if #(.REG_ADDR_W(5), .MC_LAT_W(4), .CNT_W(16)) bus ();

  pipeline_hazard_sb #(.REG_ADDR_W(5), .NREGS(32), .MC_LAT_W(4), .CNT_W(16)) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic d_set(input logic v, input logic rf, input logic u1, input logic u2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.valid_D = v; bus.reg_flag_D = rf; bus.use_rs1_D = u1; bus.use_rs2_D = u2;
    bus.rs1_D = rs1; bus.rs2_D = rs2; bus.rd_D = rd;
  endtask

  task automatic w_set(input logic flag, input logic [4:0] rd);
    bus.reg_flag_W = flag; bus.rd_W = rd;
  endtask

  task automatic e_set(input logic br, input logic mc, input logic [3:0] lat);
    bus.branch_E = br; bus.mc_start_E = mc; bus.mc_lat_E = lat;
  endtask

  // One cycle: push expected mode, compare at the falling edge, update model.
  task automatic cyc(input logic [10:0] exp_vec, input string tag);
    logic [10:0] obs;
    logic [10:0] e;
    exp_q.push_back(exp_vec);
    @(negedge clk);
    obs = {bus.enable_IFU, bus.enable_F_D, bus.enable_D_R, bus.enable_R_E, bus.enable_E_W,
           bus.flush_IFU, bus.flush_F_D, bus.flush_D_R, bus.flush_R_E, bus.flush_E_W,
           bus.mc_busy};
    e = exp_q.pop_front();
    check(tag, {21'b0, obs}, {21'b0, e});
    check({tag, "_stall_cycles"}, {16'b0, bus.stall_cycles}, exp_stall);
    check({tag, "_flush_events"}, {16'b0, bus.flush_events}, exp_flush);
    if (rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (e == V_STALL || e == V_FRZ) exp_stall++;
      if (e == V_BR) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    d_set(0, 0, 0, 0, 0, 0, 0);
    w_set(0, 0);
    e_set(0, 0, 0);
    cyc(V_DEF, "reset_state");
    rst = 1'b0;
    cyc(V_DEF, "idle");

    // RAW on x5: stall until retire, issue the cycle after retire.
    d_set(1, 1, 0, 0, 0, 0, 5);
    cyc(V_DEF, "issue_x5");
    d_set(1, 0, 1, 0, 5, 0, 0);
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) cyc(V_STALL, "raw_stall_x5");
    w_set(1, 5);
    cyc(V_STALL, "retire_same_cycle_stall");
    w_set(0, 0);
    cyc(V_DEF, "issue_after_retire");

    // x0 never tracked; unused source ignores stale pend; WAW stall.
    d_set(1, 1, 0, 0, 0, 0, 0);
    cyc(V_DEF, "write_x0");
    d_set(1, 0, 1, 0, 0, 0, 0);
    cyc(V_DEF, "read_x0_no_stall");
    d_set(1, 1, 0, 0, 0, 0, 9);
    cyc(V_DEF, "issue_x9");
    d_set(1, 0, 0, 0, 0, 9, 0);
    cyc(V_DEF, "unused_rs2_no_stall");
    d_set(1, 1, 0, 0, 0, 0, 9);
    cyc(V_STALL, "waw_stall_x9");
    w_set(1, 9);
    cyc(V_STALL, "waw_retire_cycle");
    w_set(0, 0);
    d_set(0, 0, 0, 0, 0, 0, 0);
    cyc(V_DEF, "after_waw");

    // Branch rollback of x7 sitting in R; D's x8 must not issue.
    d_set(1, 1, 0, 0, 0, 0, 7);
    cyc(V_DEF, "issue_x7");
    d_set(1, 1, 0, 0, 0, 0, 8);
    e_set(1, 0, 0);
    cyc(V_BR, "branch_flush");
    e_set(0, 0, 0);
    d_set(1, 0, 1, 1, 7, 8, 0);
    cyc(V_DEF, "rollback_x7_no_issue_x8");

    // Multi-cycle latency 3, branch and hazard ignored while frozen.
    d_set(0, 0, 0, 0, 0, 0, 0);
    e_set(0, 1, 3);
    cyc(V_FRZ, "mc3_c0");
    e_set(1, 1, 3);
    d_set(1, 1, 0, 0, 0, 0, 4);
    cyc(V_FRZ, "mc3_c1_branch_ignored");
    e_set(0, 1, 3);
    d_set(0, 0, 0, 0, 0, 0, 0);
    cyc(V_FRZ, "mc3_c2");
    cyc(V_DEF, "mc3_release_no_retrigger");
    e_set(0, 0, 0);
    cyc(V_DEF, "mc3_idle");

    // Latency 0 and branch+mc_start do not freeze; latency 1 boundary.
    e_set(0, 1, 0);
    cyc(V_DEF, "mc_lat0_no_freeze");
    e_set(1, 1, 2);
    cyc(V_BR, "branch_beats_mc");
    e_set(0, 0, 0);
    cyc(V_DEF, "after_branch_mc");
    e_set(0, 1, 1);
    cyc(V_FRZ, "mc1_freeze");
    cyc(V_DEF, "mc1_release");
    e_set(0, 0, 0);
    cyc(V_DEF, "mc1_idle");

    // Reset during a 5-cycle freeze with x3 pending.
    d_set(1, 1, 0, 0, 0, 0, 3);
    cyc(V_DEF, "issue_x3");
    d_set(0, 0, 0, 0, 0, 0, 0);
    e_set(0, 1, 5);
    cyc(V_FRZ, "mc5_c0");
    e_set(0, 0, 0);
    cyc(V_FRZ, "mc5_c1");
    rst = 1'b1;
    cyc(V_DEF, "reset_during_freeze");
    rst = 1'b0;
    d_set(1, 0, 1, 0, 3, 0, 0);
    cyc(V_DEF, "post_reset_pend_clear");
    d_set(0, 0, 0, 0, 0, 0, 0);
    cyc(V_DEF, "post_reset_idle");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_sb.md
# pipeline_hazard_sb

Scoreboard-based hazard and flow-control unit for the 5-stage F/D/R/E/W pipeline. It generates latch enables and flushes for F_D, D_R, R_E, E_W and the IFU. It tracks outstanding register writes in a per-register pending scoreboard instead of comparing against fixed stage distances. It adds multi-cycle execute freezes, branch rollback of the scoreboard, and saturating performance counters.

## Interface
- REG_ADDR_W, 5, register address width
- NREGS, 32, architectural registers (2**REG_ADDR_W); register 0 is never tracked
- MC_LAT_W, 4, width of multi-cycle latency field
- CNT_W, 16, performance counter width
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- valid_D, reg_flag_D  in  1  D holds a valid instruction / it writes rd_D
- use_rs1_D, use_rs2_D  in  1  D reads rs1_D / rs2_D
- rs1_D, rs2_D, rd_D  in  REG_ADDR_W  D-stage register addresses
- rd_W  in  REG_ADDR_W, reg_flag_W  in  1  write-back this cycle
- branch_E  in  1  taken branch resolved in E
- mc_start_E  in  1, mc_lat_E  in  MC_LAT_W  E holds a multi-cycle op needing mc_lat_E cycles
- enable_IFU, enable_F_D, enable_D_R, enable_R_E, enable_E_W  out  1  latch enables
- flush_IFU, flush_F_D, flush_D_R, flush_R_E, flush_E_W  out  1  latch flushes (bubble insert)
- mc_busy  out  1  freeze due to multi-cycle op
- stall_cycles, flush_events  out  CNT_W  saturating counters

## Operation
- Scoreboard pend[NREGS-1:0], reset 0. Stall on any hazard: data_stall = valid_D & ((use_rs1_D & rs1_D!=0 & pend[rs1_D]) | (use_rs2_D & rs2_D!=0 & pend[rs2_D]) | (reg_flag_D & rd_D!=0 & pend[rd_D])). The last term is the WAW stall, which guarantees at most one write in flight per register.
- Issue: if valid_D & reg_flag_D & rd_D!=0 and D advances into R unflushed, set pend[rd_D]. Record tag_R = {1, rd_D}. Otherwise tag_R = 0 when D_R loads or flushes.
- Retire: reg_flag_W & rd_W!=0 clears pend[rd_W].
- Rollback: when flush_R_E is asserted and tag_R is valid, clear pend[tag_R.rd]. tag_R is cleared on flush_R_E and also when R advances into E.
- Multi-cycle FSM: IDLE, BUSY, RELEASE.
  - IDLE: if mc_start_E & mc_lat_E!=0 & !branch_E, freeze this cycle and load cnt = mc_lat_E-1. Go to RELEASE if mc_lat_E==1, else BUSY.
  - BUSY: freeze; cnt decrements; go to RELEASE when cnt==1.
  - RELEASE: no freeze; mc_start_E is ignored; go to IDLE.
- Freeze outputs: enable_IFU, enable_F_D, enable_D_R, enable_R_E = 0; enable_E_W = 1; flush_E_W = 1. mc_busy = 1.
- Priority: freeze > branch > data stall. branch_E and data_stall are ignored during a freeze.
- Branch: flush_IFU, flush_F_D, flush_D_R, flush_R_E = 1; all enables 1. No issue happens this cycle.
- Data stall: enable_IFU = 0, enable_F_D = 0, flush_D_R = 1; R, E and W advance.
- Default: all enables 1, all flushes 0.
- Retire processing continues in every mode.
- stall_cycles increments in each freeze or data-stall cycle. flush_events increments in each branch-flush cycle. Both saturate at all-ones.

## Timing
- All outputs are combinational from the inputs and registered state. pend, tag_R, the FSM and the counters update at the clock edge.
- pend changes become visible the next cycle. A retire at cycle t therefore still stalls a dependent instruction in D at cycle t; D issues at t+1.
- A multi-cycle op with latency N accepted at cycle t freezes cycles t..t+N-1. The E_W latch captures the result at the edge ending cycle t+N.
- Reset: pend = 0, tag_R = 0, FSM = IDLE, cnt = 0, counters = 0. Outputs revert to default in the same cycle reset is sampled; an in-progress freeze is aborted.
- Simultaneous issue and retire of different registers are both applied. Issue and retire of the same register cannot both occur in one cycle, because the WAW stall blocks the issue.

## Test plan
- Write x5 issued at t, dependent reader of x5 in D from t+1 → data_stall each cycle until rd_W=5/reg_flag_W at cycle u; D issues at u+1; stall_cycles = u-t.
- Reader with rs1_D=0, or use_rs1_D=0 with a stale pend → no stall.
- Issue rd=7, then branch_E while it sits in R → flush_R_E=1; pend[7]=0 next cycle; flush_events=1.
- mc_start_E with mc_lat_E=3 at cycle 10 → mc_busy and flush_E_W high cycles 10-12; cycle 13 enables all 1 with mc_start_E still high and no re-trigger.
- mc_lat_E=0 → no freeze. branch_E and mc_start_E together → branch flush, no freeze.
- Assert reset at cycle 2 of a 5-cycle freeze → next cycle all enables 1, mc_busy 0, counters 0, pend 0.
